priv_1_12_trap_sequencer: RTL and testbench
===========================================

# priv_1_12_trap_sequencer

Cycle-level sequencer between the privilege block's interrupt/exception handler and the pipeline. It decides when a trap or xRET is taken and drives the PC redirect. On a trap or return request it drains the pipeline and pulses a commit strobe so the handler injects mcause/mepc/mstatus. It then computes the redirect target from mtvec (direct or vectored) or mepc and holds the redirect until fetch accepts it.

## Interface
Parameters:
- VECTOR_EN, 1, when 0 the vectored mtvec mode is treated as direct.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- intr  in  1  handler reports a pending enabled interrupt.
- exception  in  1  handler reports a synchronous exception.
- mret  in  1  machine-return instruction in commit.
- sret  in  1  supervisor return; ignored, no redirect in this release.
- uret  in  1  user return; ignored, no redirect in this release.
- pipe_clear  in  1  pipeline has no outstanding hazards or in-flight stores.
- pc_accept  in  1  fetch consumed the redirect this cycle.
- curr_mtvec  in  32  mtvec; [1:0] mode, [31:2] base.
- curr_mcause  in  32  mcause; [31] interrupt, [30:0] code.
- curr_mepc  in  32  mepc.
- flush_req  out  1  request pipeline drain/squash.
- trap_commit  out  1  one-cycle strobe; handler injects CSRs on this edge.
- ret_commit  out  1  one-cycle strobe; handler restores mstatus on this edge.
- insert_pc  out  1  redirect valid.
- priv_pc  out  32  redirect target; stable while insert_pc is high.
- busy  out  1  sequencer not IDLE.

## Operation
- States: IDLE, DRAIN, COMMIT, TARGET, REDIRECT.
- IDLE: exception|intr → DRAIN, kind=TRAP. Otherwise mret → DRAIN, kind=RET. Otherwise stay.
- Simultaneous trap and mret in IDLE: TRAP wins, and mret is dropped.
- DRAIN: flush_req=1. Stays in DRAIN until pipe_clear=1, then goes to COMMIT.
- COMMIT: pulses trap_commit (TRAP) or ret_commit (RET) for exactly one cycle, then goes to TARGET.
- TARGET: one cycle. The handler's CSR writes are visible here. The sequencer registers priv_pc from the values below, then goes to REDIRECT.
  - RET: priv_pc = {curr_mepc[31:2], 2'b00}.
  - TRAP, direct: mode≠01, or VECTOR_EN=0, or mcause[31]=0. priv_pc = {base, 2'b00}.
  - TRAP, vectored: mode=01 and mcause[31]=1. priv_pc = {base, 2'b00} + (mcause[30:0] << 2). Addition is mod 2^32; wrap is not flagged.
- REDIRECT: insert_pc=1 and priv_pc held. On pc_accept, go to IDLE.
- Requests arriving outside IDLE are ignored. The handler keeps them asserted and they are re-sampled in IDLE. An interrupt during a RET sequence is taken only after the RET redirect completes.
- sret and uret never start a sequence.

## Timing
- Reset values: state=IDLE; flush_req, trap_commit, ret_commit, insert_pc, busy = 0; priv_pc=0.
- All outputs are registered or decoded from registered state only. No input-to-output combinational path.
- Minimum latency, request sampled at edge N with pipe_clear already 1:
  - DRAIN in N+1.
  - COMMIT in N+2.
  - TARGET in N+3.
  - insert_pc high in N+4.
  - Earliest return to IDLE is N+5, if pc_accept=1 in N+4.
- flush_req stays high in DRAIN, COMMIT and TARGET, and drops in REDIRECT.
- busy = (state≠IDLE).
- RST asserted mid-sequence: immediate return to IDLE with reset output values. No commit strobe is emitted.
- pc_accept outside REDIRECT is ignored.

## Structure
- In the shared machine_mode_types_1_12_pkg:
  - trap_seq_state_t (enum, 3-bit).
  - trap_kind_t (TRAP/RET).
  - localparam MTVEC_MODE_VECTORED = 2'b01.
  - mtvec_t and mcause_t, reused from the same package.
- Sub-module priv_1_12_trap_target: combinational priv_pc computation, instantiated once and registered in TARGET.

## Test plan
- Exception, mtvec=0x0000_1000 direct, pipe_clear=1, pc_accept=1 at first REDIRECT cycle → trap_commit one cycle at N+2; insert_pc at N+4 with priv_pc=0x1000; busy low at N+5.
- Interrupt, mtvec=0x0000_2001 vectored, mcause=0x8000_0007 → priv_pc=0x201C. Same stimulus with VECTOR_EN=0 → priv_pc=0x2000.
- mret, mepc=0x8000_0102, pipe_clear held 0 for 5 cycles → flush_req high throughout DRAIN; ret_commit only after pipe_clear rises; priv_pc=0x8000_0100.
- intr and mret in the same cycle → TRAP path; ret_commit never pulses. Exception raised during DRAIN is ignored and taken after return to IDLE.
- pc_accept held 0 for 4 cycles in REDIRECT → insert_pc and priv_pc stable for all 4 cycles; IDLE one cycle after pc_accept=1.
- RST asserted in COMMIT and in REDIRECT → all outputs 0 in the same cycle; no stray strobe after release. sret/uret alone → busy stays 0.

Source files
------------

// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared machine-mode types for the privilege block.
// Holds trap sequencer states, trap kinds and CSR field layouts.
package machine_mode_types_1_12_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_TARGET   = 3'd3,
    ST_REDIRECT = 3'd4
  } trap_seq_state_t;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_RET  = 1'b1
  } trap_kind_t;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  typedef struct packed {
    logic        irq;
    logic [30:0] code;
  } mcause_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/priv_1_12_trap_sequencer_if.sv
// Handshake bundle between the trap sequencer,
// the privilege handler and the pipeline front end.
interface priv_1_12_trap_sequencer_if;
  logic        intr;
  logic        exception;
  logic        mret;
  logic        sret;
  logic        uret;
  logic        pipe_clear;
  logic        pc_accept;
  logic [31:0] curr_mtvec;
  logic [31:0] curr_mcause;
  logic [31:0] curr_mepc;
  logic        flush_req;
  logic        trap_commit;
  logic        ret_commit;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        busy;

  modport master (
    input  intr, exception, mret, sret, uret,
    input  pipe_clear, pc_accept,
    input  curr_mtvec, curr_mcause, curr_mepc,
    output flush_req, trap_commit, ret_commit,
    output insert_pc, priv_pc, busy
  );

  modport slave (
    output intr, exception, mret, sret, uret,
    output pipe_clear, pc_accept,
    output curr_mtvec, curr_mcause, curr_mepc,
    input  flush_req, trap_commit, ret_commit,
    input  insert_pc, priv_pc, busy
  );
endinterface

// File: rtl/priv_1_12_trap_target.sv
// Redirect target for a trap (mtvec direct/vectored)
// or a machine return (mepc, word aligned).
module priv_1_12_trap_target
  import machine_mode_types_1_12_pkg::*;
#(
  parameter bit VECTOR_EN = 1'b1
) (
  input  trap_kind_t  kind_i,
  input  mtvec_t      mtvec_i,
  input  mcause_t     mcause_i,
  input  logic [31:0] mepc_i,
  output logic [31:0] target_o
);

  logic        vect;
  logic [31:0] base;
  logic [31:0] off;

  always_comb begin
    base = {mtvec_i.base, 2'b00};
    vect = VECTOR_EN
         && (mtvec_i.mode == MTVEC_MODE_VECTORED)
         && mcause_i.irq;
    // code << 2 truncated to 32 bits; wrap is silent
    off  = vect ? {mcause_i.code[29:0], 2'b00} : 32'd0;
    if (kind_i == KIND_RET)
      target_o = word_align(mepc_i);
    else
      target_o = base + off;
  end

endmodule

// File: rtl/priv_1_12_trap_sequencer.sv
// Trap/xRET sequencer: drain, commit strobe,
// target computation and held PC redirect.
module priv_1_12_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter bit VECTOR_EN = 1'b1
) (
  input logic CLK,
  input logic RST,
  priv_1_12_trap_sequencer_if.master bus
);

  trap_seq_state_t state_q, state_d;
  trap_kind_t      kind_q, kind_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     target;
  logic            unused_xret;

  assign unused_xret = bus.sret | bus.uret;

  priv_1_12_trap_target #(
    .VECTOR_EN (VECTOR_EN)
  ) u_target (
    .kind_i   (kind_q),
    .mtvec_i  (mtvec_t'(bus.curr_mtvec)),
    .mcause_i (mcause_t'(bus.curr_mcause)),
    .mepc_i   (bus.curr_mepc),
    .target_o (target)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_TRAP;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE: begin
        // trap outranks a same-cycle mret
        if (bus.exception | bus.intr) begin
          state_d = ST_DRAIN;
          kind_d  = KIND_TRAP;
        end else if (bus.mret) begin
          state_d = ST_DRAIN;
          kind_d  = KIND_RET;
        end
      end
      ST_DRAIN: begin
        if (bus.pipe_clear)
          state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_TARGET;
      end
      ST_TARGET: begin
        pc_d    = target;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (bus.pc_accept)
          state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.flush_req   = (state_q == ST_DRAIN)
                        || (state_q == ST_COMMIT)
                        || (state_q == ST_TARGET);
  assign bus.trap_commit = (state_q == ST_COMMIT)
                        && (kind_q == KIND_TRAP);
  assign bus.ret_commit  = (state_q == ST_COMMIT)
                        && (kind_q == KIND_RET);
  assign bus.insert_pc   = (state_q == ST_REDIRECT);
  assign bus.priv_pc     = pc_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// Randomized + directed bench for the trap sequencer,
// checked against a transaction-level reference model.
module tb_priv_1_12_trap_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        intr, exc, mret, sret, uret;
  logic        pclr, pacc;
  logic [31:0] mtvec, mcause, mepc;

  priv_1_12_trap_sequencer_if ifv ();
  priv_1_12_trap_sequencer_if ifd ();

  assign ifv.intr        = intr;
  assign ifv.exception   = exc;
  assign ifv.mret        = mret;
  assign ifv.sret        = sret;
  assign ifv.uret        = uret;
  assign ifv.pipe_clear  = pclr;
  assign ifv.pc_accept   = pacc;
  assign ifv.curr_mtvec  = mtvec;
  assign ifv.curr_mcause = mcause;
  assign ifv.curr_mepc   = mepc;

  assign ifd.intr        = intr;
  assign ifd.exception   = exc;
  assign ifd.mret        = mret;
  assign ifd.sret        = sret;
  assign ifd.uret        = uret;
  assign ifd.pipe_clear  = pclr;
  assign ifd.pc_accept   = pacc;
  assign ifd.curr_mtvec  = mtvec;
  assign ifd.curr_mcause = mcause;
  assign ifd.curr_mepc   = mepc;

  priv_1_12_trap_sequencer #(.VECTOR_EN(1'b1)) dut_v (
    .CLK (clk),
    .RST (rst),
    .bus (ifv)
  );

  priv_1_12_trap_sequencer #(.VECTOR_EN(1'b0)) dut_d (
    .CLK (clk),
    .RST (rst),
    .bus (ifd)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  // reference: step index through the sequence
  // 0 idle, 1 drain, 2 commit, 3 target, 4 redirect
  int          step;
  bit          is_ret;
  logic [31:0] pc_v, pc_d;

  function automatic logic [31:0] ref_pc(input bit ven);
    logic [31:0] t;
    if (is_ret) return mepc & 32'hFFFF_FFFC;
    t = mtvec & 32'hFFFF_FFFC;
    if (ven && mtvec[1:0] == 2'b01 && mcause[31])
      t = t + ((mcause & 32'h7FFF_FFFF) * 4);
    return t;
  endfunction

  task automatic model_reset();
    step = 0;
    pc_v = 32'd0;
    pc_d = 32'd0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    case (step)
      0: begin
        if (exc || intr) begin
          is_ret = 1'b0;
          step   = 1;
        end else if (mret) begin
          is_ret = 1'b1;
          step   = 1;
        end
      end
      1: if (pclr) step = 2;
      2: step = 3;
      3: begin
        pc_v = ref_pc(1'b1);
        pc_d = ref_pc(1'b0);
        step = 4;
      end
      default: if (pacc) step = 0;
    endcase
  endtask

  task automatic check_outs();
    logic fl, tc, rc, ip, bz;
    fl = (step >= 1 && step <= 3);
    tc = (step == 2) && !is_ret;
    rc = (step == 2) && is_ret;
    ip = (step == 4);
    bz = (step != 0);
    chk("v.flush_req", 32'(ifv.flush_req), 32'(fl));
    chk("v.trap_commit", 32'(ifv.trap_commit), 32'(tc));
    chk("v.ret_commit", 32'(ifv.ret_commit), 32'(rc));
    chk("v.insert_pc", 32'(ifv.insert_pc), 32'(ip));
    chk("v.busy", 32'(ifv.busy), 32'(bz));
    chk("v.priv_pc", ifv.priv_pc, pc_v);
    chk("d.flush_req", 32'(ifd.flush_req), 32'(fl));
    chk("d.trap_commit", 32'(ifd.trap_commit), 32'(tc));
    chk("d.ret_commit", 32'(ifd.ret_commit), 32'(rc));
    chk("d.insert_pc", 32'(ifd.insert_pc), 32'(ip));
    chk("d.busy", 32'(ifd.busy), 32'(bz));
    chk("d.priv_pc", ifd.priv_pc, pc_d);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic clear_reqs();
    intr = 0; exc = 0; mret = 0;
    sret = 0; uret = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (step != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(step != 0), 32'd0);
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    chk("rst.any_out",
        32'({ifv.flush_req, ifv.trap_commit,
             ifv.ret_commit, ifv.insert_pc, ifv.busy}),
        32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    pclr = 0; pacc = 0;
    mtvec = 0; mcause = 0; mepc = 0;
    model_reset();
    is_ret = 1'b0;
    @(negedge clk);
    check_outs();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // exception, direct mtvec, minimum latency
    mtvec = 32'h0000_1000;
    mcause = 32'h0000_0002;
    pclr = 1; pacc = 1; exc = 1;
    tick();
    exc = 0;
    tick();
    chk("t1.trap_commit", 32'(ifv.trap_commit), 32'd1);
    tick();
    tick();
    chk("t1.insert_pc", 32'(ifv.insert_pc), 32'd1);
    chk("t1.priv_pc", ifv.priv_pc, 32'h0000_1000);
    tick();
    chk("t1.busy", 32'(ifv.busy), 32'd0);

    // vectored interrupt vs VECTOR_EN=0
    mtvec = 32'h0000_2001;
    mcause = 32'h8000_0007;
    intr = 1;
    tick();
    intr = 0;
    repeat (3) tick();
    chk("t2.pc_vec", ifv.priv_pc, 32'h0000_201C);
    chk("t2.pc_novec", ifd.priv_pc, 32'h0000_2000);
    wait_idle(8);

    // mret with slow drain
    mepc = 32'h8000_0102;
    pclr = 0; mret = 1;
    tick();
    mret = 0;
    repeat (5) tick();
    pclr = 1;
    tick();
    chk("t3.ret_commit", 32'(ifv.ret_commit), 32'd1);
    tick();
    tick();
    chk("t3.priv_pc", ifv.priv_pc, 32'h8000_0100);
    wait_idle(8);

    // intr+mret together; exception held during drain
    pclr = 0; intr = 1; mret = 1;
    tick();
    intr = 0; mret = 0; exc = 1;
    repeat (2) tick();
    pclr = 1;
    repeat (5) tick();
    exc = 0;
    wait_idle(12);

    // redirect held while fetch stalls
    pacc = 0; exc = 1;
    tick();
    exc = 0;
    repeat (3) tick();
    repeat (4) tick();
    chk("t5.still_ins", 32'(ifv.insert_pc), 32'd1);
    pacc = 1;
    tick();
    chk("t5.busy", 32'(ifv.busy), 32'd0);

    // reset in COMMIT, then in REDIRECT
    exc = 1;
    tick();
    exc = 0;
    tick();
    reset_now();
    repeat (3) tick();
    pacc = 0; mret = 1;
    tick();
    mret = 0;
    repeat (3) tick();
    reset_now();
    repeat (3) tick();

    // sret/uret never start a sequence
    sret = 1; uret = 1;
    repeat (4) tick();
    chk("t7.busy", 32'(ifv.busy), 32'd0);
    clear_reqs();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      intr = ($urandom_range(0, 15) == 0);
      exc  = ($urandom_range(0, 15) == 0);
      mret = ($urandom_range(0, 7) == 0);
      sret = $urandom_range(0, 1);
      uret = $urandom_range(0, 1);
      pclr = ($urandom_range(0, 3) != 0);
      pacc = ($urandom_range(0, 2) != 0);
      mtvec  = $urandom;
      mcause = $urandom;
      mepc   = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        reset_now();
      end else begin
        tick();
      end
    end
    clear_reqs();
    pclr = 1; pacc = 1;
    wait_idle(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
